// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment display path.
//   seg7_t      : segment vector {g,f,e,d,c,b,a}, active-high
//   state_t     : handshake/conversion state of the scanner top
//   SEG_BLANK   : all segments off
//   SEG_DASH    : middle bar only, shown on every digit while overflowed
//   bcd_to_seg  : BCD nibble to segment pattern; non-BCD codes go dark
package seven_seg_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

  localparam seg7_t SEG_BLANK = 7'b0000000;
  localparam seg7_t SEG_DASH  = 7'b1000000;

  function automatic seg7_t bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
//   clock, reset : clock and asynchronous active-high reset
//   start        : load value and begin (ignored while busy)
//   value        : unsigned binary input
//   busy         : conversion in progress
//   done         : high during the cycle whose closing edge performs the last step
//   bcd          : result of the step taken at the coming edge; valid as the
//                  final result when done is high
// Digits beyond DIGITS*4 bits are discarded; the caller flags overflow.
module bin_to_bcd #(
  parameter int VALUE_BITS = 14,
  parameter int DIGITS     = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VALUE_BITS-1:0] value,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int BW    = DIGITS * 4;
  localparam int CNT_W = (VALUE_BITS > 1) ? $clog2(VALUE_BITS) : 1;

  logic                  r_busy;
  logic [VALUE_BITS-1:0] r_shift;
  logic [BW-1:0]         r_acc;
  logic [CNT_W-1:0]      r_count;
  logic [BW-1:0]         w_adj;
  logic [BW-1:0]         w_acc_next;

  // Add-3 correction on every nibble >= 5, then shift the next binary bit in.
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
    end
    w_acc_next = {w_adj[BW-2:0], r_shift[VALUE_BITS-1]};
  end

  assign busy = r_busy;
  assign done = r_busy && (r_count == CNT_W'(VALUE_BITS - 1));
  assign bcd  = w_acc_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_shift <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (start && !r_busy) begin
      r_busy  <= 1'b1;
      r_shift <= value;
      r_acc   <= '0;
      r_count <= '0;
    end else if (r_busy) begin
      r_acc   <= w_acc_next;
      r_shift <= r_shift << 1;
      r_count <= r_count + CNT_W'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-cathode 7-segment driver fed by a valid/ready handshake.
//   clock, reset  : clock and asynchronous active-high reset
//   value_valid   : value is presented
//   value_ready   : high only in IDLE; a value transfers on an edge where
//                   value_valid and value_ready are both high; value_valid
//                   while not ready is ignored and need not be held
//   value         : unsigned binary value to display
//   segments      : {g,f,e,d,c,b,a}, active-high, registered
//   digit_enable  : one-hot digit select, bit 0 = least significant, registered
//   overflow      : latched, displayed value >= 10**DIGITS
// The display registers change only on the final conversion edge, so the
// scan never shows a partially converted number.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int VALUE_BITS   = 14,
  parameter int SCAN_CYCLES  = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic [VALUE_BITS-1:0] value,
  output seg7_t                 segments,
  output logic [DIGITS-1:0]     digit_enable,
  output logic                  overflow
);

  localparam int          SLOT_W    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0] OVF_LIMIT = 32'(10 ** DIGITS);

  state_t                r_state, w_state_next;
  logic                  w_start, w_busy, w_done;
  logic [DIGITS*4-1:0]   w_bcd;
  logic [DIGITS*4-1:0]   r_digits;
  logic                  r_overflow, r_ovf_next;
  logic [SLOT_W-1:0]     r_slot;
  logic [IDX_W-1:0]      r_index;
  logic [IDX_W-1:0]      w_msd;
  logic [3:0]            w_cur_digit;
  logic [DIGITS-1:0]     w_en_next;
  seg7_t                 w_seg_next;
  logic [DIGITS-1:0]     r_digit_enable;
  seg7_t                 r_segments;

  bin_to_bcd #(.VALUE_BITS(VALUE_BITS), .DIGITS(DIGITS)) u_bin_to_bcd (
    .clock (clock),
    .reset (reset),
    .start (w_start),
    .value (value),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // Handshake FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    value_ready  = (r_state == ST_IDLE) && !w_busy;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (value_valid && value_ready) begin
          w_start      = 1'b1;
          w_state_next = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (w_done) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Overflow is decided at acceptance and committed together with the digits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf_next <= 1'b0;
      r_digits   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_start) r_ovf_next <= (32'(value) >= OVF_LIMIT);
      if (w_done) begin
        r_digits   <= w_bcd;
        r_overflow <= r_ovf_next;
      end
    end
  end

  // Free-running slot counter and digit index
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_slot  <= '0;
      r_index <= '0;
    end else if (r_slot == SLOT_W'(SCAN_CYCLES - 1)) begin
      r_slot  <= '0;
      r_index <= (r_index == IDX_W'(DIGITS - 1)) ? '0 : r_index + IDX_W'(1);
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
    end
  end

  // Most significant non-zero digit; stays 0 for an all-zero value so digit 0 shows.
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (r_digits[i*4 +: 4] != 4'd0) w_msd = IDX_W'(i);
    end
  end

  always_comb begin
    w_cur_digit = r_digits[4*r_index +: 4];
    w_en_next   = '0;
    w_seg_next  = SEG_BLANK;
    if (r_slot >= SLOT_W'(BLANK_CYCLES)) begin
      if (r_overflow) begin
        w_en_next  = DIGITS'(1) << r_index;
        w_seg_next = SEG_DASH;
      end else if (r_index <= w_msd) begin
        w_en_next  = DIGITS'(1) << r_index;
        w_seg_next = bcd_to_seg(w_cur_digit);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digit_enable <= '0;
      r_segments     <= SEG_BLANK;
    end else begin
      r_digit_enable <= w_en_next;
      r_segments     <= w_seg_next;
    end
  end

  assign digit_enable = r_digit_enable;
  assign segments     = r_segments;
  assign overflow     = r_overflow;

endmodule
